// File: rtl/plugboard_prog.sv
// plugboard_prog: runtime-programmable Enigma plugboard with a registered one-hot letter permutation stage.
// Optional build macro PLUGBOARD_DEFAULT_MAP_EN: reset and clear load the standard 12-pair map instead of identity.
module plugboard_prog #(
   parameter int N_LETTERS = 26,
   parameter int MAX_PAIRS = 13,
   parameter int IDX_W     = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_clear,
   input  logic                 cfg_valid,
   input  logic [IDX_W-1:0]     cfg_a,
   input  logic [IDX_W-1:0]     cfg_b,
   output logic                 cfg_ready,
   output logic                 cfg_err,
   output logic [IDX_W-1:0]     pair_count,
   input  logic                 in_valid,
   input  logic [N_LETTERS-1:0] in_letter,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [N_LETTERS-1:0] out_letter,
   input  logic                 out_ready
);
   typedef enum logic [1:0] {IDLE, CHECK, WRITE, CLEAR} state_t;
`ifdef PLUGBOARD_DEFAULT_MAP_EN
   localparam int DEF_MAP [26] = '{25, 2, 1, 24, 20, 15, 12, 22, 18, 21, 19, 11, 6,
                                   16, 14, 5, 13, 23, 8, 10, 4, 9, 7, 17, 3, 0};
   localparam logic [IDX_W-1:0] INIT_PAIRS = IDX_W'(12);
   if (N_LETTERS != 26) begin : g_bad_alphabet
      $error("PLUGBOARD_DEFAULT_MAP_EN requires N_LETTERS == 26");
   end
   function automatic logic [IDX_W-1:0] reset_entry(input int i);
      return IDX_W'(DEF_MAP[i]);
   endfunction
`else
   localparam logic [IDX_W-1:0] INIT_PAIRS = '0;
   function automatic logic [IDX_W-1:0] reset_entry(input int i);
      return IDX_W'(i);
   endfunction
`endif
   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       a_q, a_d, b_q, b_d;
   logic [IDX_W-1:0]       map_q [N_LETTERS];
   logic [IDX_W-1:0]       map_d [N_LETTERS];
   logic [IDX_W-1:0]       pair_count_q, pair_count_d;
   logic                   out_valid_q, out_valid_d;
   logic [N_LETTERS-1:0]   out_letter_q, out_letter_d, perm;
   logic                   reject, accept;
   // Latched pair is only checked after a cycle, so the table lookup is registered-input only.
   assign reject = (a_q == b_q) | (int'(a_q) >= N_LETTERS) | (int'(b_q) >= N_LETTERS) |
                   (map_q[a_q] != a_q) | (map_q[b_q] != b_q) |
                   (pair_count_q == IDX_W'(MAX_PAIRS));
   // State and captured pair registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end
   // Config FSM next state; a clear request in IDLE always beats a pending pair.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      case (state_q)
         IDLE: begin
            if (cfg_clear) state_d = CLEAR;
            else if (cfg_valid) begin
               state_d = CHECK;
               a_d     = cfg_a;
               b_d     = cfg_b;
            end
         end
         CHECK:   state_d = reject ? IDLE : WRITE;
         default: state_d = IDLE;
      endcase
   end
   // Config FSM outputs; letters only flow in IDLE so the map never changes under a letter in flight.
   always_comb begin
      cfg_ready = (state_q == IDLE) & !cfg_clear;
      cfg_err   = (state_q == CHECK) & reject;
      in_ready  = (state_q == IDLE) & !cfg_clear & (!out_valid_q | out_ready);
   end
   // Table update: WRITE installs both halves of the pair so the map stays an involution.
   always_comb begin
      map_d        = map_q;
      pair_count_d = pair_count_q;
      if (state_q == WRITE) begin
         map_d[a_q]   = b_q;
         map_d[b_q]   = a_q;
         pair_count_d = pair_count_q + 1'b1;
      end else if (state_q == CLEAR) begin
         for (int i = 0; i < N_LETTERS; i++) map_d[i] = reset_entry(i);
         pair_count_d = INIT_PAIRS;
      end
   end
   // Swap table and pair counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_LETTERS; i++) map_q[i] <= reset_entry(i);
         pair_count_q <= INIT_PAIRS;
      end else begin
         map_q        <= map_d;
         pair_count_q <= pair_count_d;
      end
   end
   // Bitwise permutation; non-one-hot inputs pass through with popcount preserved.
   always_comb begin
      perm = '0;
      for (int j = 0; j < N_LETTERS; j++) perm[j] = in_letter[map_q[j]];
   end
   // Output stage next state: load on accept, drop valid once consumed, otherwise hold.
   always_comb begin
      accept       = in_valid & in_ready;
      out_valid_d  = accept | (out_valid_q & !out_ready);
      out_letter_d = accept ? perm : out_letter_q;
   end
   // Output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_letter_q <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_letter_q <= out_letter_d;
      end
   end
   assign pair_count = pair_count_q;
   assign out_valid  = out_valid_q;
   assign out_letter = out_letter_q;
endmodule

// File: tb/tb_plugboard_prog.sv
// tb_plugboard_prog: directed self-checking bench for plugboard_prog (default identity-map build).
module tb_plugboard_prog;
   localparam int N = 26;
   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_clear, cfg_valid, cfg_ready, cfg_err;
   logic [4:0]    cfg_a, cfg_b, pair_count;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [N-1:0]  in_letter, out_letter;
   int            n_checks = 0;
   int            n_errors = 0;
   plugboard_prog dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_clear  (cfg_clear),
      .cfg_valid  (cfg_valid),
      .cfg_a      (cfg_a),
      .cfg_b      (cfg_b),
      .cfg_ready  (cfg_ready),
      .cfg_err    (cfg_err),
      .pair_count (pair_count),
      .in_valid   (in_valid),
      .in_letter  (in_letter),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_letter (out_letter),
      .out_ready  (out_ready)
   );
   always #5 clk = ~clk;
   function automatic logic [N-1:0] oh(input int k);
      logic [N-1:0] one = 1;
      return one << k;
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // Offer one letter with out_ready high and check the registered result one cycle later.
   task automatic send(input string tag, input logic [N-1:0] v, input logic [N-1:0] e);
      @(negedge clk);
      in_valid  = 1'b1;
      in_letter = v;
      #1 check({tag, "_rdy"}, 32'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, "_vld"}, 32'(out_valid), 1);
      check(tag, 32'(out_letter), 32'(e));
   endtask
   // Offer one config pair and check the cfg_err pulse across CHECK and the following cycle.
   task automatic cfg(input string tag, input int a, input int b, input logic err);
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_a     = 5'(a);
      cfg_b     = 5'(b);
      #1 check({tag, "_rdy"}, 32'(cfg_ready), 1);
      @(negedge clk);
      cfg_valid = 1'b0;
      check({tag, "_err"}, 32'(cfg_err), 32'(err));
      @(negedge clk);
      check({tag, "_err_end"}, 32'(cfg_err), 0);
      @(negedge clk);
   endtask
   initial begin
      rst_n = 1'b0; cfg_clear = 1'b0; cfg_valid = 1'b0; cfg_a = '0; cfg_b = '0;
      in_valid = 1'b0; in_letter = '0; out_ready = 1'b1;
      #2;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_letter", 32'(out_letter), 0);
      check("rst_pairs", 32'(pair_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      // 1: identity map
      send("id_A", oh(0), oh(0));
      send("id_C", oh(2), oh(2));
      send("id_Z", oh(25), oh(25));
      check("id_pairs", 32'(pair_count), 0);
      // 2: two pairs
      cfg("p_AZ", 0, 25, 1'b0);
      cfg("p_BC", 1, 2, 1'b0);
      check("pairs2", 32'(pair_count), 2);
      send("A_Z", oh(0), oh(25));
      send("Z_A", oh(25), oh(0));
      send("B_C", oh(1), oh(2));
      send("D_D", oh(3), oh(3));
      send("AB_ZC", oh(0) | oh(1), oh(25) | oh(2));
      send("zero", '0, '0);
      // 3: rejects
      cfg("rej_same", 4, 4, 1'b1);
      cfg("rej_range", 4, 30, 1'b1);
      cfg("rej_plugged", 0, 5, 1'b1);
      check("rej_pairs", 32'(pair_count), 2);
      send("rej_E", oh(4), oh(4));
      send("rej_A", oh(0), oh(25));
      for (int k = 3; k < 24; k += 2) cfg("fill", k, k + 1, 1'b0);
      check("pairs13", 32'(pair_count), 13);
      cfg("rej_14th", 3, 5, 1'b1);
      check("pairs13_hold", 32'(pair_count), 13);
      send("D_E", oh(3), oh(4));
      // 4: backpressure
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_letter = oh(5);
      @(negedge clk);
      check("bp_vld1", 32'(out_valid), 1);
      check("bp_let1", 32'(out_letter), 32'(oh(6)));
      in_letter = oh(7);
      #1 check("bp_blocked", 32'(in_ready), 0);
      @(negedge clk);
      check("bp_hold_vld", 32'(out_valid), 1);
      check("bp_hold_let", 32'(out_letter), 32'(oh(6)));
      out_ready = 1'b1;
      #1 check("bp_open", 32'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_vld2", 32'(out_valid), 1);
      check("bp_let2", 32'(out_letter), 32'(oh(8)));
      @(negedge clk);
      check("bp_drain", 32'(out_valid), 0);
      // 5: clear beats a pair
      cfg_clear = 1'b1;
      cfg_valid = 1'b1;
      cfg_a     = 5'd0;
      cfg_b     = 5'd1;
      #1;
      check("clr_cfg_rdy", 32'(cfg_ready), 0);
      check("clr_in_rdy", 32'(in_ready), 0);
      @(negedge clk);
      cfg_clear = 1'b0;
      cfg_valid = 1'b0;
      @(negedge clk);
      check("clr_pairs", 32'(pair_count), 0);
      send("clr_A", oh(0), oh(0));
      send("clr_B", oh(1), oh(1));
      // 6: async reset with a letter held in the output register
      cfg("p_CD", 2, 3, 1'b0);
      check("pairs1", 32'(pair_count), 1);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_letter = oh(2);
      @(negedge clk);
      in_valid = 1'b0;
      check("pre_rst_let", 32'(out_letter), 32'(oh(3)));
      #2 rst_n = 1'b0;
      #1;
      check("arst_vld", 32'(out_valid), 0);
      check("arst_let", 32'(out_letter), 0);
      check("arst_pairs", 32'(pair_count), 0);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      send("arst_C", oh(2), oh(2));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
